qpl_mb_allocator: RTL

- Multi-block successor to the single-block QPL line allocator.
- Tracks free-line counts for BLOCKS independent heap blocks and converts byte-size requests into line counts (ceiling).
- Picks a block with enough space and returns {udata, status, block id, lines, virtual base} on a registered reply stream.
- Sits between the PU request/reply streams and the per-block deallocators; virtual-to-physical translation stays downstream.

---
 rtl/qpl_mb_allocator.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/qpl_mb_allocator.sv
// Multi-block QPL line allocator: ceiling byte-to-line conversion, first-fit block pick, registered reply.
// Optional macro QPL_MB_ALLOC_RR_EN switches block selection to round-robin.
module qpl_mb_allocator #(
  parameter int LINE_S  = 256,
  parameter int BLOCK_D = 512,
  parameter int BLOCKS  = 4,
  parameter int UDATA_W = 8,
  localparam int LINE_W  = $clog2(LINE_S),
  localparam int BLOCK_W = $clog2(BLOCK_D),
  localparam int BID_W   = (BLOCKS > 1) ? $clog2(BLOCKS) : 1,
  localparam int SIZE_W  = $clog2(BLOCK_D * LINE_S) + 1,
  localparam int CNT_W   = BLOCK_W + 1,
  localparam int REQ_W   = UDATA_W + SIZE_W,
  localparam int REP_W   = UDATA_W + 1 + BID_W + CNT_W + BLOCK_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_req_alloc_vld,
  input  logic [REQ_W-1:0]          i_req_alloc_data,
  output logic                      o_req_alloc_rdy,
  output logic                      o_rep_alloc_vld,
  output logic [REP_W-1:0]          o_rep_alloc_data,
  input  logic                      i_rep_alloc_rdy,
  input  logic [BLOCKS-1:0]         i_dealloc_vld,
  input  logic [BLOCKS*CNT_W-1:0]   i_dealloc_lines,
  output logic [BLOCKS*CNT_W-1:0]   o_avail,
  output logic [BLOCKS-1:0]         o_full,
  output logic                      o_err
);

  logic [CNT_W-1:0]   avail_q [BLOCKS];
  logic [CNT_W-1:0]   avail_d [BLOCKS];
  logic [CNT_W-1:0]   dl_lines_s [BLOCKS];
  logic [BLOCKS-1:0]  full_q, full_d;
  logic               err_q, err_d;
  logic               rep_vld_q, rep_vld_d;
  logic [REP_W-1:0]   rep_data_q, rep_data_d;

  logic [UDATA_W-1:0] req_udata_s;
  logic [SIZE_W-1:0]  req_size_s;
  logic [CNT_W:0]     lines_wide_s;
  logic               accept_s;
  logic               found_s;
  logic               fail_s;
  logic               alloc_ok_s;
  logic [BID_W-1:0]   sel_s;
  logic [BID_W-1:0]   idx_s;
  logic [CNT_W-1:0]   used_s;
  logic [CNT_W:0]     sum_s;

`ifdef QPL_MB_ALLOC_RR_EN
  logic [BID_W-1:0]   rr_q, rr_d;
  logic [BID_W:0]     rr_sum_s;
`endif

  assign req_udata_s  = i_req_alloc_data[REQ_W-1:SIZE_W];
  assign req_size_s   = i_req_alloc_data[SIZE_W-1:0];
  // Extra top bit keeps the largest size's ceiling from wrapping to zero.
  assign lines_wide_s = {1'b0, req_size_s[SIZE_W-1:LINE_W]}
                      + {{CNT_W{1'b0}}, (|req_size_s[LINE_W-1:0])};

  assign o_req_alloc_rdy = i_rst_n && (!rep_vld_q || i_rep_alloc_rdy);
  assign accept_s        = i_req_alloc_vld && o_req_alloc_rdy;

  always_comb begin
    found_s = 1'b0;
    sel_s   = '0;
    idx_s   = '0;
`ifdef QPL_MB_ALLOC_RR_EN
    rr_sum_s = '0;
`endif
    for (int i = 0; i < BLOCKS; i++) begin
`ifdef QPL_MB_ALLOC_RR_EN
      rr_sum_s = {1'b0, rr_q} + (BID_W+1)'(i);
      if (rr_sum_s >= (BID_W+1)'(BLOCKS)) begin
        rr_sum_s = rr_sum_s - (BID_W+1)'(BLOCKS);
      end else begin
        rr_sum_s = rr_sum_s;
      end
      idx_s = rr_sum_s[BID_W-1:0];
`else
      idx_s = BID_W'(i);
`endif
      if (!found_s && ({1'b0, avail_q[idx_s]} >= lines_wide_s)) begin
        found_s = 1'b1;
        sel_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign fail_s     = (lines_wide_s == '0) || (lines_wide_s > (CNT_W+1)'(BLOCK_D)) || !found_s;
  assign alloc_ok_s = accept_s && !fail_s;
  assign used_s     = CNT_W'(BLOCK_D) - avail_q[sel_s];

  always_comb begin
    for (int b = 0; b < BLOCKS; b++) begin
      dl_lines_s[b]         = i_dealloc_lines[b*CNT_W +: CNT_W];
      o_avail[b*CNT_W +: CNT_W] = avail_q[b];
    end
  end

  // Net per-block update: allocation and deallocation in the same cycle both apply.
  always_comb begin
    err_d  = err_q;
    full_d = '0;
    sum_s  = '0;
    for (int b = 0; b < BLOCKS; b++) begin
      sum_s = {1'b0, avail_q[b]};
      if (alloc_ok_s && (sel_s == BID_W'(b))) begin
        sum_s = sum_s - lines_wide_s;
      end else begin
        sum_s = sum_s;
      end
      if (i_dealloc_vld[b]) begin
        sum_s = sum_s + {1'b0, dl_lines_s[b]};
      end else begin
        sum_s = sum_s;
      end
      if (sum_s > (CNT_W+1)'(BLOCK_D)) begin
        avail_d[b] = CNT_W'(BLOCK_D);
        err_d      = 1'b1;
      end else begin
        avail_d[b] = sum_s[CNT_W-1:0];
      end
      full_d[b] = (avail_d[b] == '0);
    end
  end

  always_comb begin
    rep_vld_d  = rep_vld_q && !i_rep_alloc_rdy;
    rep_data_d = rep_data_q;
    if (accept_s) begin
      rep_vld_d = 1'b1;
      if (fail_s) begin
        rep_data_d = {req_udata_s, 1'b1, {BID_W{1'b0}}, lines_wide_s[CNT_W-1:0], {BLOCK_W{1'b0}}};
      end else begin
        rep_data_d = {req_udata_s, 1'b0, sel_s, lines_wide_s[CNT_W-1:0], used_s[BLOCK_W-1:0]};
      end
    end else begin
      rep_data_d = rep_data_q;
    end
  end

`ifdef QPL_MB_ALLOC_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (alloc_ok_s) begin
      if (sel_s == BID_W'(BLOCKS - 1)) begin
        rr_d = '0;
      end else begin
        rr_d = sel_s + BID_W'(1);
      end
    end else begin
      rr_d = rr_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < BLOCKS; b++) begin
        avail_q[b] <= CNT_W'(BLOCK_D);
      end
      full_q     <= '0;
      err_q      <= 1'b0;
      rep_vld_q  <= 1'b0;
      rep_data_q <= '0;
    end else begin
      for (int b = 0; b < BLOCKS; b++) begin
        avail_q[b] <= avail_d[b];
      end
      full_q     <= full_d;
      err_q      <= err_d;
      rep_vld_q  <= rep_vld_d;
      rep_data_q <= rep_data_d;
    end
  end

  assign o_full           = full_q;
  assign o_err            = err_q;
  assign o_rep_alloc_vld  = rep_vld_q;
  assign o_rep_alloc_data = rep_data_q;

endmodule
